// File: rtl/serial_adder.sv
// Digit-serial adder: adds DIGIT bits per clock over WIDTH/DIGIT steps, then
// presents a registered sum, carry-out and two's-complement overflow for one DONE cycle.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_i,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C_o,
  output logic             V
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, s_q, s_d;
  logic             carry_q, carry_d, co_q, co_d, v_q, v_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT:0]   dfull;
  logic [WIDTH-1:0] dsum_w;
  logic             c_msb;

  always_comb begin
    dfull  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + (DIGIT+1)'(carry_q);
    // Carry into the digit's top bit, recovered from its sum bit and operands.
    c_msb  = dfull[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
    dsum_w = '0;
    dsum_w[WIDTH-1 -: DIGIT] = dfull[DIGIT-1:0];

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    co_d    = co_q;
    v_d     = v_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = C_i;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        sum_d   = (sum_q >> DIGIT) | dsum_w;
        carry_d = dfull[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          s_d     = sum_d;
          co_d    = dfull[DIGIT];
          v_d     = c_msb ^ dfull[DIGIT];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      v_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      co_q    <= co_d;
      v_q     <= v_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign S    = s_q;
  assign C_o  = co_q;
  assign V    = v_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: four WIDTH=8 instances with DIGIT = 1, 2, 4, 8 on a shared
// clock and reset; directed vectors plus back-to-back random operations per instance.
module tb_serial_adder;

  localparam int NI = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [NI-1:0]       start_v, ci_v, busy_v, done_v, co_v, v_v;
  logic [NI-1:0][7:0]  a_v, b_v, s_v;

  int checks = 0;
  int errs   = 0;

  logic [7:0] last_s  [NI];
  logic       last_co [NI];
  logic       last_v  [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    serial_adder #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
      .clk   (clk),
      .reset (reset),
      .start (start_v[g]),
      .A     (a_v[g]),
      .B     (b_v[g]),
      .C_i   (ci_v[g]),
      .busy  (busy_v[g]),
      .done  (done_v[g]),
      .S     (s_v[g]),
      .C_o   (co_v[g]),
      .V     (v_v[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_last();
    for (int i = 0; i < NI; i++) begin
      last_s[i]  = 8'h00;
      last_co[i] = 1'b0;
      last_v[i]  = 1'b0;
    end
  endtask

  // One operation on instance i; mid=1 re-pulses start and scrambles inputs during RUN.
  task automatic do_op(input int i, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input bit mid, input string tag);
    logic [8:0] full;
    logic       ev;
    int         n, lat, bcnt;
    n    = 8 >> i;
    full = {1'b0, a} + {1'b0, b} + 9'(ci);
    ev   = (a[7] == b[7]) && (full[7] != a[7]);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done_v[i]), 32'd0);
    start_v[i] = 1'b1;
    a_v[i]     = a;
    b_v[i]     = b;
    ci_v[i]    = ci;
    @(negedge clk);
    start_v[i] = 1'b0;
    chk({tag, "_hold_s"},  32'(s_v[i]),  32'(last_s[i]));
    chk({tag, "_hold_co"}, 32'(co_v[i]), 32'(last_co[i]));
    lat  = 0;
    bcnt = 0;
    while (!done_v[i] && lat < 40) begin
      if (busy_v[i]) bcnt++;
      if (mid) begin
        start_v[i] = 1'b1;
        a_v[i]     = ~a_v[i];
        b_v[i]     = a_v[i] ^ 8'h5A;
        ci_v[i]    = ~ci_v[i];
      end
      @(negedge clk);
      lat++;
    end
    start_v[i] = 1'b0;
    chk({tag, "_latency"}, 32'(lat),  32'(n));
    chk({tag, "_busy"},    32'(bcnt), 32'(n));
    chk({tag, "_busy_in_done"}, 32'(busy_v[i]), 32'd0);
    chk({tag, "_s"},  32'(s_v[i]),  32'(full[7:0]));
    chk({tag, "_co"}, 32'(co_v[i]), 32'(full[8]));
    chk({tag, "_v"},  32'(v_v[i]),  32'(ev));
    last_s[i]  = full[7:0];
    last_co[i] = full[8];
    last_v[i]  = ev;
  endtask

  initial begin
    int dcnt;
    reset   = 1'b1;
    start_v = '0;
    ci_v    = '0;
    a_v     = '0;
    b_v     = '0;
    clr_last();

    // start held high while reset is asserted must not launch anything
    repeat (2) @(negedge clk);
    start_v = '1;
    a_v     = '1;
    b_v     = '1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_busy", 32'(busy_v[i]), 32'd0);
      chk("rst_done", 32'(done_v[i]), 32'd0);
      chk("rst_s",    32'(s_v[i]),    32'd0);
      chk("rst_co",   32'(co_v[i]),   32'd0);
      chk("rst_v",    32'(v_v[i]),    32'd0);
    end
    start_v = '0;
    reset   = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", 32'(busy_v), 32'd0);

    do_op(0, 8'h00, 8'h00, 1'b0, 1'b0, "zero_d1");
    do_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, "wrap_d1");
    do_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, "ovf_d1");
    do_op(2, 8'h80, 8'h80, 1'b1, 1'b0, "neg_ovf_d4");
    do_op(0, 8'h5A, 8'h3C, 1'b1, 1'b1, "midchg_d1");
    do_op(1, 8'hC3, 8'h81, 1'b0, 1'b1, "midchg_d2");
    do_op(3, 8'h40, 8'h40, 1'b0, 1'b0, "ovf_d8");
    for (int i = 0; i < NI; i++) do_op(i, 8'hFF, 8'hFF, 1'b1, 1'b0, "ones");

    // abort in the 4th RUN cycle with a reset pulse between clock edges
    do_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, "pre_rst");
    @(negedge clk);
    start_v[0] = 1'b1;
    a_v[0]     = 8'hAA;
    b_v[0]     = 8'h55;
    ci_v[0]    = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_before_rst", 32'(busy_v[0]), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("async_busy", 32'(busy_v[0]), 32'd0);
    chk("async_done", 32'(done_v[0]), 32'd0);
    chk("async_s",    32'(s_v[0]),    32'd0);
    chk("async_co",   32'(co_v[0]),   32'd0);
    chk("async_v",    32'(v_v[0]),    32'd0);
    #1 reset = 1'b0;
    clr_last();
    dcnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_v[0]) dcnt++;
    end
    chk("no_done_after_abort", 32'(dcnt), 32'd0);
    do_op(0, 8'h12, 8'h34, 1'b0, 1'b0, "post_rst");

    for (int i = 0; i < NI; i++)
      for (int k = 0; k < 250; k++)
        do_op(i, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, "rnd");

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
